sdp_arbiter: RTL
================

SDP_ARBITER -- requirements
Module: sdp_arbiter

Interface
REQ-001 Parameter: DATA_W, 8, operand and result width.
REQ-002 Port: clk  in  1  clock, all state updates on rising edge.
REQ-003 Port: reset  in  1  synchronous, active-high reset.
REQ-004 Port: req0_valid  in  1  requester 0 has an operation pending.
REQ-005 Port: req0_ready  out  1  requester 0 operation accepted this cycle.
REQ-006 Port: req0_op  in  2  bit0: 1 = a+b, 0 = a-b; bit1: 1 = +c, 0 = -c.
REQ-007 Port: req0_a, req0_b, req0_c  in  DATA_W each  requester 0 operands.
REQ-008 Port: req1_valid, req1_ready, req1_op, req1_a, req1_b, req1_c  same widths and meanings as REQ-004..007, for requester 1.
REQ-009 Port: resp_valid  out  1  result present.
REQ-010 Port: resp_ready  in  1  consumer accepts result.
REQ-011 Port: resp_id  out  1  requester that issued the result.
REQ-012 Port: resp_data  out  DATA_W  result.

Function
REQ-013 The block SHALL share one 3-stage add/sub pipeline between two requesters.
- S1: captures op, a, b, c, id, valid.
- S2: m = op0 ? a+b : a-b.
- S3: n = op1 ? m+c : m-c.
- All arithmetic modulo 2^DATA_W; wrap-around is silent.
REQ-014 advance = !resp_valid || resp_ready; all stages SHALL shift together when advance=1 and SHALL hold unchanged when advance=0.
- Global stall; bubbles are not compressed.
REQ-015 Latency SHALL be exactly 3 cycles from acceptance to resp_valid when no stall occurs; each stall cycle adds one cycle.
REQ-016 Grant selection SHALL be round-robin via a 1-bit pointer ptr:
- Both valid: grant = ptr.
- One valid: grant that requester.
- None valid: no grant.
REQ-017 reqN_ready SHALL equal advance && reqN_valid && grant==N; at most one ready is high per cycle.
REQ-018 On an accepted transfer from requester N, ptr SHALL become !N next cycle; ptr is unchanged otherwise.
REQ-019 Requesters SHALL hold valid, op and operands stable until ready; the block does not latch unaccepted requests.
REQ-020 While resp_valid=1 and resp_ready=0, resp_data and resp_id SHALL remain stable and no new request SHALL be accepted.
REQ-021 When advance=1 and no request is accepted, a bubble (valid=0) SHALL enter S1.
REQ-022 Results SHALL be delivered in acceptance order, each exactly once.

Reset
REQ-023 When reset=1 at a clock edge, all of the following SHALL clear to 0:
- stage valid bits, stage data and ids, ptr;
- resp_valid, resp_id, resp_data;
- counters.
REQ-024 While reset=1, req0_ready and req1_ready SHALL be 0.
REQ-025 Reset asserted mid-operation SHALL discard all in-flight operations with no response produced.
REQ-026 All state SHALL also initialise to 0 at time zero.

Configuration
REQ-027 With macro SDP_ARB_GNT_CNT_EN defined:
- Outputs gnt_cnt0 and gnt_cnt1 (out, 16 each) SHALL exist.
- Each counts accepted transfers of its requester.
- Each saturates at 0xFFFF.
- Each clears on reset.
REQ-028 Without SDP_ARB_GNT_CNT_EN, those ports and counters SHALL be absent; all other behaviour is identical.

Structure
REQ-029 Package sdp_arb_pkg SHALL hold:
- DATA_W default;
- op encodings OP_ADD_ADD, OP_ADD_SUB, OP_SUB_ADD, OP_SUB_SUB;
- typedef sdp_req_t {op, a, b, c, id}.
REQ-030 The stallable tagged datapath SHALL be sub-module sdp_arb_pipe; arbitration, ptr and counters reside in sdp_arbiter.

Verification
REQ-031 Requester 0 only, op=2'b11, a=10, b=20, c=5, resp_ready=1 -> resp_valid 3 cycles after acceptance, data=35, id=0.
REQ-032 Requester 1, op=2'b00, a=3, b=10, c=250 -> data=255 (wrap), id=1.
REQ-033 Both valid every cycle after reset -> grants alternate 0,1,0,1; responses alternate id 0,1,0,1.
REQ-034 resp_ready held 0 for 4 cycles with full pipe:
- both ready signals 0;
- resp_data stable;
- on release, the 3 results emerge in order with no loss or duplication.
REQ-035 reset pulsed with 2 operations in flight -> no resp_valid afterwards; ptr=0; a subsequent single request completes in 3 cycles.
REQ-036 With SDP_ARB_GNT_CNT_EN defined, 5 accepts on requester 0 and 2 on requester 1 -> gnt_cnt0=5, gnt_cnt1=2.

Source files
------------

// File: rtl/sdp_arb_pkg.sv
// sdp_arb_pkg
// Shared definitions for the two-requester add/sub arbiter:
//   SDP_DATA_W  - default operand/result width
//   OP_*        - operation encodings (bit0: 1 = a+b / 0 = a-b,
//                                      bit1: 1 = +c  / 0 = -c)
//   sdp_req_t   - one granted request as presented to the pipeline
package sdp_arb_pkg;

  localparam int SDP_DATA_W = 8;

  localparam logic [1:0] OP_ADD_ADD = 2'b11;  // (a + b) + c
  localparam logic [1:0] OP_ADD_SUB = 2'b01;  // (a + b) - c
  localparam logic [1:0] OP_SUB_ADD = 2'b10;  // (a - b) + c
  localparam logic [1:0] OP_SUB_SUB = 2'b00;  // (a - b) - c

  typedef struct packed {
    logic [1:0]            op;
    logic [SDP_DATA_W-1:0] a;
    logic [SDP_DATA_W-1:0] b;
    logic [SDP_DATA_W-1:0] c;
    logic                  id;
  } sdp_req_t;

endpackage

// File: rtl/sdp_arb_pipe.sv
// sdp_arb_pipe
// Three-stage stallable add/sub datapath carrying a requester tag.
//   S1 captures the request, S2 forms m = a +/- b, S3 forms n = m +/- c.
//   All stages shift together on i_advance and hold otherwise; bubbles
//   travel with the rest of the pipe (no compression).
// Ports:
//   clk, reset          - clock, synchronous active-high reset
//   i_advance           - shift enable for every stage
//   i_valid/i_op/i_a/i_b/i_c/i_id - request entering S1
//   o_valid/o_id/o_data - S3 contents (registered result)
module sdp_arb_pipe
  import sdp_arb_pkg::*;
#(
  parameter int DATA_W = SDP_DATA_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              i_advance,
  input  logic              i_valid,
  input  logic [1:0]        i_op,
  input  logic [DATA_W-1:0] i_a,
  input  logic [DATA_W-1:0] i_b,
  input  logic [DATA_W-1:0] i_c,
  input  logic              i_id,
  output logic              o_valid,
  output logic              o_id,
  output logic [DATA_W-1:0] o_data
);

  logic              r_s1_valid = 1'b0;
  logic [1:0]        r_s1_op    = 2'b00;
  logic [DATA_W-1:0] r_s1_a     = '0;
  logic [DATA_W-1:0] r_s1_b     = '0;
  logic [DATA_W-1:0] r_s1_c     = '0;
  logic              r_s1_id    = 1'b0;

  logic              r_s2_valid = 1'b0;
  logic              r_s2_op1   = 1'b0;
  logic [DATA_W-1:0] r_s2_m     = '0;
  logic [DATA_W-1:0] r_s2_c     = '0;
  logic              r_s2_id    = 1'b0;

  logic              r_s3_valid = 1'b0;
  logic [DATA_W-1:0] r_s3_n     = '0;
  logic              r_s3_id    = 1'b0;

  logic [DATA_W-1:0] w_m;
  logic [DATA_W-1:0] w_n;

  // Stage arithmetic; widths match so wrap-around is silent modulo 2^DATA_W.
  always_comb begin
    w_m = '0;
    w_n = '0;
    if (r_s1_op[0]) begin
      w_m = r_s1_a + r_s1_b;
    end else begin
      w_m = r_s1_a - r_s1_b;
    end
    if (r_s2_op1) begin
      w_n = r_s2_m + r_s2_c;
    end else begin
      w_n = r_s2_m - r_s2_c;
    end
  end

  // Pipeline registers: clear on reset, shift as one on advance, else hold.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_s1_valid <= 1'b0;
      r_s1_op    <= 2'b00;
      r_s1_a     <= '0;
      r_s1_b     <= '0;
      r_s1_c     <= '0;
      r_s1_id    <= 1'b0;
      r_s2_valid <= 1'b0;
      r_s2_op1   <= 1'b0;
      r_s2_m     <= '0;
      r_s2_c     <= '0;
      r_s2_id    <= 1'b0;
      r_s3_valid <= 1'b0;
      r_s3_n     <= '0;
      r_s3_id    <= 1'b0;
    end else if (i_advance) begin
      r_s1_valid <= i_valid;
      r_s1_op    <= i_op;
      r_s1_a     <= i_a;
      r_s1_b     <= i_b;
      r_s1_c     <= i_c;
      r_s1_id    <= i_id;
      r_s2_valid <= r_s1_valid;
      r_s2_op1   <= r_s1_op[1];
      r_s2_m     <= w_m;
      r_s2_c     <= r_s1_c;
      r_s2_id    <= r_s1_id;
      r_s3_valid <= r_s2_valid;
      r_s3_n     <= w_n;
      r_s3_id    <= r_s2_id;
    end
  end

  assign o_valid = r_s3_valid;
  assign o_id    = r_s3_id;
  assign o_data  = r_s3_n;

endmodule

// File: rtl/sdp_arbiter.sv
// sdp_arbiter
// Round-robin arbiter sharing one 3-stage add/sub pipeline between two
// requesters. Results come back tagged with the issuing requester, in
// acceptance order; a stalled response (resp_valid && !resp_ready) freezes
// the whole pipe and blocks new acceptances.
// Ports:
//   clk, reset                         - clock, synchronous active-high reset
//   reqN_valid/op/a/b/c, reqN_ready    - requester N (N = 0, 1) handshake
//   resp_valid/resp_ready/resp_id/resp_data - result handshake
// Optional build macro SDP_ARB_GNT_CNT_EN adds gnt_cnt0/gnt_cnt1: 16-bit
// saturating counts of accepted transfers per requester.
// The request struct in sdp_arb_pkg is sized by SDP_DATA_W, so DATA_W is
// expected to stay at the package default.
module sdp_arbiter
  import sdp_arb_pkg::*;
#(
  parameter int DATA_W = SDP_DATA_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req0_valid,
  output logic              req0_ready,
  input  logic [1:0]        req0_op,
  input  logic [DATA_W-1:0] req0_a,
  input  logic [DATA_W-1:0] req0_b,
  input  logic [DATA_W-1:0] req0_c,
  input  logic              req1_valid,
  output logic              req1_ready,
  input  logic [1:0]        req1_op,
  input  logic [DATA_W-1:0] req1_a,
  input  logic [DATA_W-1:0] req1_b,
  input  logic [DATA_W-1:0] req1_c,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic              resp_id,
  output logic [DATA_W-1:0] resp_data
`ifdef SDP_ARB_GNT_CNT_EN
  ,
  output logic [15:0]       gnt_cnt0,
  output logic [15:0]       gnt_cnt1
`endif
);

  logic     r_ptr = 1'b0;  // requester that wins when both are valid
  logic     w_advance;
  logic     w_gnt_any;
  logic     w_gnt_id;
  logic     w_accept;
  sdp_req_t w_sel;

  assign w_advance = !resp_valid || resp_ready;

  // Grant selection and request mux; reset forces no acceptance.
  always_comb begin
    w_gnt_any = req0_valid || req1_valid;
    w_gnt_id  = 1'b0;
    if (req0_valid && req1_valid) begin
      w_gnt_id = r_ptr;
    end else begin
      w_gnt_id = req1_valid;
    end
    w_accept = !reset && w_advance && w_gnt_any;
    if (w_gnt_id) begin
      w_sel = '{op: req1_op, a: req1_a, b: req1_b, c: req1_c, id: 1'b1};
    end else begin
      w_sel = '{op: req0_op, a: req0_a, b: req0_b, c: req0_c, id: 1'b0};
    end
  end

  assign req0_ready = w_accept && !w_gnt_id;
  assign req1_ready = w_accept &&  w_gnt_id;

  // Round-robin pointer: after a grant, the other requester gets priority.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_ptr <= 1'b0;
    end else if (w_accept) begin
      r_ptr <= !w_gnt_id;
    end
  end

`ifdef SDP_ARB_GNT_CNT_EN
  logic [15:0] r_gnt_cnt0 = 16'h0000;
  logic [15:0] r_gnt_cnt1 = 16'h0000;

  // Per-requester acceptance counters, saturating at all-ones.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_gnt_cnt0 <= 16'h0000;
      r_gnt_cnt1 <= 16'h0000;
    end else begin
      if (req0_ready && (r_gnt_cnt0 != 16'hFFFF)) begin
        r_gnt_cnt0 <= r_gnt_cnt0 + 16'h0001;
      end
      if (req1_ready && (r_gnt_cnt1 != 16'hFFFF)) begin
        r_gnt_cnt1 <= r_gnt_cnt1 + 16'h0001;
      end
    end
  end

  assign gnt_cnt0 = r_gnt_cnt0;
  assign gnt_cnt1 = r_gnt_cnt1;
`endif

  sdp_arb_pipe #(
    .DATA_W (DATA_W)
  ) u_pipe (
    .clk       (clk),
    .reset     (reset),
    .i_advance (w_advance),
    .i_valid   (w_accept),
    .i_op      (w_sel.op),
    .i_a       (w_sel.a),
    .i_b       (w_sel.b),
    .i_c       (w_sel.c),
    .i_id      (w_sel.id),
    .o_valid   (resp_valid),
    .o_id      (resp_id),
    .o_data    (resp_data)
  );

endmodule
